operand_issue: RTL and testbench

Single-entry operand-fetch and issue stage that sits on the read side of the register file of `register_cell` instances. It accepts one decoded instruction at a time and stalls while any needed source or destination register is write-reserved. Same-cycle write-back data is forwarded to the source operands. When hazards clear, it latches the operands, pulses the destination's write-reserve line, and presents the operands to the execute stage over a valid/ready handshake.

---
 rtl/operand_issue_if.sv | 54 +++++
 rtl/operand_issue.sv | 130 +++++++++++++
 tb/tb_operand_issue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/operand_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_issue_if
// Description : Register-file read, write-back snoop, instruction-in and
//               issue-out signal bundle for the operand_issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_issue_if #(
  parameter int LEN_REG   = 32,
  parameter int N_REG     = 16,
  parameter int LEN_REGNO = 4
);
  // register file view
  logic [N_REG*LEN_REG-1:0] data_i;
  logic [N_REG-1:0]         w_reserve_i;
  logic [N_REG-1:0]         reserve_o;
  // write-back snoop
  logic                     wb_valid_i;
  logic [LEN_REGNO-1:0]     wb_regno_i;
  logic [LEN_REG-1:0]       wb_data_i;
  // decoded instruction in
  logic                     insn_valid_i;
  logic                     insn_ready_o;
  logic [LEN_REGNO-1:0]     rs1_i;
  logic [LEN_REGNO-1:0]     rs2_i;
  logic [LEN_REGNO-1:0]     rd_i;
  logic                     use_rs1_i;
  logic                     use_rs2_i;
  logic                     use_rd_i;
  // issue to execute
  logic                     issue_valid_o;
  logic                     issue_ready_i;
  logic [LEN_REG-1:0]       op1_o;
  logic [LEN_REG-1:0]       op2_o;
  logic [LEN_REGNO-1:0]     rd_o;
  logic                     use_rd_o;

  // stage side
  modport slave (
    input  data_i, w_reserve_i, wb_valid_i, wb_regno_i, wb_data_i,
    input  insn_valid_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i, use_rd_i,
    input  issue_ready_i,
    output reserve_o, insn_ready_o, issue_valid_o, op1_o, op2_o, rd_o, use_rd_o
  );

  // environment side (decoder, register file, execute)
  modport master (
    output data_i, w_reserve_i, wb_valid_i, wb_regno_i, wb_data_i,
    output insn_valid_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i, use_rd_i,
    output issue_ready_i,
    input  reserve_o, insn_ready_o, issue_valid_o, op1_o, op2_o, rd_o, use_rd_o
  );
endinterface
`default_nettype wire

// File: rtl/operand_issue.sv
`default_nettype none
// ============================================================================
// Module      : operand_issue
// Description : Single-entry operand fetch / issue stage. Stalls on register
//               write reservations, forwards same-cycle write-back data,
//               pulses the destination reserve line and hands operands to
//               execute over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_issue #(
  parameter int LEN_REG   = 32,
  parameter int N_REG     = 16,
  parameter int LEN_REGNO = 4
) (
  input  logic clk,
  input  logic rst,
  operand_issue_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_next;

  // latched instruction fields
  logic [LEN_REGNO-1:0] rs1, rs2, rd;
  logic                 use_rs1, use_rs2, use_rd;

  // operand holding registers
  logic [LEN_REG-1:0]   op1, op2;

  // per-register view of the flat register-file bus
  logic [LEN_REG-1:0]   regs [N_REG];

  for (genvar k = 0; k < N_REG; k++) begin : g_unpack
    assign regs[k] = bus.data_i[k*LEN_REG +: LEN_REG];
  end

  // forwarding hits and hazard evaluation on the latched fields
  logic hit1, hit2, hitd;
  logic src1_ok, src2_ok, dst_ok, go, accept;
  logic [LEN_REG-1:0] val1, val2;

  assign hit1    = bus.wb_valid_i && (bus.wb_regno_i == rs1);
  assign hit2    = bus.wb_valid_i && (bus.wb_regno_i == rs2);
  assign hitd    = bus.wb_valid_i && (bus.wb_regno_i == rd);
  assign src1_ok = !use_rs1 || !bus.w_reserve_i[rs1] || hit1;
  assign src2_ok = !use_rs2 || !bus.w_reserve_i[rs2] || hit2;
  assign dst_ok  = !use_rd  || !bus.w_reserve_i[rd]  || hitd;
  assign go      = (state == HOLD) && src1_ok && src2_ok && dst_ok;
  assign accept  = (state == EMPTY) && bus.insn_valid_i;

  // an unused source reads as zero; otherwise forwarded data wins over the file
  assign val1 = !use_rs1 ? '0 : (hit1 ? bus.wb_data_i : regs[rs1]);
  assign val2 = !use_rs2 ? '0 : (hit2 ? bus.wb_data_i : regs[rs2]);

  // state register; reset drops any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // next-state and combinational outputs
  always_comb begin
    state_next        = state;
    bus.reserve_o     = '0;
    bus.insn_ready_o  = 1'b0;
    bus.issue_valid_o = 1'b0;
    case (state)
      EMPTY: begin
        bus.insn_ready_o = 1'b1;
        if (bus.insn_valid_i) state_next = HOLD;
      end
      HOLD: begin
        if (go) begin
          if (use_rd) bus.reserve_o[rd] = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        bus.issue_valid_o = 1'b1;
        if (bus.issue_ready_i) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // capture instruction fields on accept; they stay frozen through OUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      use_rs1 <= 1'b0;
      use_rs2 <= 1'b0;
      use_rd  <= 1'b0;
    end else if (accept) begin
      rs1     <= bus.rs1_i;
      rs2     <= bus.rs2_i;
      rd      <= bus.rd_i;
      use_rs1 <= bus.use_rs1_i;
      use_rs2 <= bus.use_rs2_i;
      use_rd  <= bus.use_rd_i;
    end
  end

  // sample operands in the go cycle, before the new reservation takes effect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1 <= '0;
      op2 <= '0;
    end else if (go) begin
      op1 <= val1;
      op2 <= val2;
    end
  end

  assign bus.op1_o    = op1;
  assign bus.op2_o    = op2;
  assign bus.rd_o     = rd;
  assign bus.use_rd_o = use_rd;

endmodule
`default_nettype wire

// File: tb/tb_operand_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_issue
// Description : Directed self-checking bench for operand_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_issue;

  localparam int LEN_REG   = 32;
  localparam int N_REG     = 16;
  localparam int LEN_REGNO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  operand_issue_if #(.LEN_REG(LEN_REG), .N_REG(N_REG), .LEN_REGNO(LEN_REGNO)) bus ();

  operand_issue #(.LEN_REG(LEN_REG), .N_REG(N_REG), .LEN_REGNO(LEN_REGNO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int k, input logic [31:0] v);
    bus.data_i[k*LEN_REG +: LEN_REG] = v;
  endtask

  task automatic offer(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                       input logic u1, input logic u2, input logic ud);
    bus.insn_valid_i = 1'b1;
    bus.rs1_i = r1; bus.rs2_i = r2; bus.rd_i = d;
    bus.use_rs1_i = u1; bus.use_rs2_i = u2; bus.use_rd_i = ud;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.data_i = '0; bus.w_reserve_i = '0;
    bus.wb_valid_i = 1'b0; bus.wb_regno_i = '0; bus.wb_data_i = '0;
    bus.insn_valid_i = 1'b0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
    bus.use_rs1_i = 1'b0; bus.use_rs2_i = 1'b0; bus.use_rd_i = 1'b0;
    bus.issue_ready_i = 1'b0;

    // reset state
    #12;
    chk("rst_insn_ready", 32'(bus.insn_ready_o), 32'd1);
    chk("rst_issue_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("rst_reserve", 32'(bus.reserve_o), 32'd0);
    chk("rst_op1", bus.op1_o, 32'd0);
    chk("rst_op2", bus.op2_o, 32'd0);
    chk("rst_rd", 32'(bus.rd_o), 32'd0);
    chk("rst_use_rd", 32'(bus.use_rd_o), 32'd0);
    step();
    rst = 1'b1;

    // ---- no hazard: rs1=3, rs2=5, rd=7
    set_reg(3, 32'h11); set_reg(5, 32'h22);
    offer(4'd3, 4'd5, 4'd7, 1'b1, 1'b1, 1'b1);
    #1 chk("nh_ready", 32'(bus.insn_ready_o), 32'd1);
    step();
    bus.insn_valid_i = 1'b0;
    #1;
    chk("nh_hold_ready", 32'(bus.insn_ready_o), 32'd0);
    chk("nh_reserve", 32'(bus.reserve_o), 32'h0080);
    chk("nh_hold_valid", 32'(bus.issue_valid_o), 32'd0);
    step();
    chk("nh_reserve_off", 32'(bus.reserve_o), 32'd0);
    chk("nh_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("nh_op1", bus.op1_o, 32'h11);
    chk("nh_op2", bus.op2_o, 32'h22);
    chk("nh_rd", 32'(bus.rd_o), 32'd7);
    chk("nh_use_rd", 32'(bus.use_rd_o), 32'd1);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;
    chk("nh_empty_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("nh_empty_ready", 32'(bus.insn_ready_o), 32'd1);

    // ---- RAW stall on reg3, released by same-cycle write-back
    bus.w_reserve_i[3] = 1'b1;
    offer(4'd3, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    step();
    bus.insn_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("raw_stall_reserve", 32'(bus.reserve_o), 32'd0);
      chk("raw_stall_valid", 32'(bus.issue_valid_o), 32'd0);
      step();
    end
    bus.wb_valid_i = 1'b1; bus.wb_regno_i = 4'd3; bus.wb_data_i = 32'hABCD;
    #1 chk("raw_go_reserve", 32'(bus.reserve_o), 32'd0);
    step();
    bus.wb_valid_i = 1'b0; bus.w_reserve_i[3] = 1'b0; set_reg(3, 32'hABCD);
    chk("raw_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("raw_op1", bus.op1_o, 32'hABCD);
    chk("raw_op2", bus.op2_o, 32'd0);
    chk("raw_use_rd", 32'(bus.use_rd_o), 32'd0);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;

    // ---- WAW stall on reg7, then backpressure in OUT
    bus.w_reserve_i[7] = 1'b1;
    offer(4'd1, 4'd2, 4'd7, 1'b0, 1'b0, 1'b1);
    step();
    bus.insn_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("waw_stall_reserve", 32'(bus.reserve_o), 32'd0);
      chk("waw_stall_valid", 32'(bus.issue_valid_o), 32'd0);
      step();
    end
    bus.wb_valid_i = 1'b1; bus.wb_regno_i = 4'd7; bus.wb_data_i = 32'h55;
    #1 chk("waw_reserve", 32'(bus.reserve_o), 32'h0080);
    step();
    bus.wb_valid_i = 1'b0; set_reg(7, 32'h55);
    chk("waw_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("waw_rd", 32'(bus.rd_o), 32'd7);
    chk("waw_op1", bus.op1_o, 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.w_reserve_i = 16'($urandom);
      #1;
      chk("bp_valid", 32'(bus.issue_valid_o), 32'd1);
      chk("bp_insn_ready", 32'(bus.insn_ready_o), 32'd0);
      chk("bp_op1", bus.op1_o, 32'd0);
      chk("bp_op2", bus.op2_o, 32'd0);
      chk("bp_rd", 32'(bus.rd_o), 32'd7);
      chk("bp_reserve", 32'(bus.reserve_o), 32'd0);
      step();
    end
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;
    chk("bp_empty", 32'(bus.insn_ready_o), 32'd1);

    // ---- unused operands with every register reserved
    bus.w_reserve_i = 16'hFFFF;
    offer(4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    bus.insn_valid_i = 1'b0;
    #1 chk("un_hold_reserve", 32'(bus.reserve_o), 32'd0);
    step();
    chk("un_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("un_op1", bus.op1_o, 32'd0);
    chk("un_op2", bus.op2_o, 32'd0);
    chk("un_reserve", 32'(bus.reserve_o), 32'd0);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;

    // ---- rs1 == rs2 == rd
    bus.w_reserve_i = '0; bus.data_i = '0;
    set_reg(4, 32'hDEADBEEF);
    offer(4'd4, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1);
    step();
    bus.insn_valid_i = 1'b0;
    #1 chk("same_reserve", 32'(bus.reserve_o), 32'h0010);
    step();
    chk("same_op1", bus.op1_o, 32'hDEADBEEF);
    chk("same_op2", bus.op2_o, 32'hDEADBEEF);
    chk("same_rd", 32'(bus.rd_o), 32'd4);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;

    // ---- forward onto rs2 without a stall
    set_reg(2, 32'h2222); set_reg(6, 32'h6666);
    offer(4'd2, 4'd6, 4'd10, 1'b1, 1'b1, 1'b1);
    step();
    bus.insn_valid_i = 1'b0;
    bus.wb_valid_i = 1'b1; bus.wb_regno_i = 4'd6; bus.wb_data_i = 32'h600D;
    #1 chk("fw_reserve", 32'(bus.reserve_o), 32'h0400);
    step();
    bus.wb_valid_i = 1'b0;
    chk("fw_op1", bus.op1_o, 32'h2222);
    chk("fw_op2", bus.op2_o, 32'h600D);
    chk("fw_rd", 32'(bus.rd_o), 32'd10);
    bus.issue_ready_i = 1'b1;
    step();
    bus.issue_ready_i = 1'b0;

    // ---- reset while stalled in HOLD
    bus.w_reserve_i[8] = 1'b1;
    offer(4'd8, 4'd0, 4'd11, 1'b1, 1'b0, 1'b1);
    step();
    bus.insn_valid_i = 1'b0;
    #1 chk("rh_stalled", 32'(bus.insn_ready_o), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rh_ready", 32'(bus.insn_ready_o), 32'd1);
    chk("rh_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("rh_reserve", 32'(bus.reserve_o), 32'd0);
    step();
    rst = 1'b1;
    bus.w_reserve_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rh_no_issue", 32'(bus.issue_valid_o), 32'd0);
      chk("rh_no_reserve", 32'(bus.reserve_o), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
